hash160_seq_ctrl: RTL

- Top-level sequencer for the Hash160 datapath.
- Packs the 64-byte streamed message (i_valid/i_text) into one 512-bit block and launches the SHA-256 core on it.
- Wraps the 256-bit SHA digest in a padded RIPEMD-160 block and launches the RIPEMD-160 core.
- Streams the 160-bit result out as ten 16-bit words on o_answer/o_valid. Sits between the CHIP pads and both hash cores.

---
 rtl/hash160_pkg.sv | 27 ++
 rtl/hash160_out_ser.sv | 49 ++++
 rtl/hash160_seq_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/hash160_pkg.sv
// rtl/hash160_pkg.sv - Shared types, sizes and RIPEMD-160 pad helper for the Hash160 sequencer
package hash160_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_SHA_RUN = 3'd2,
      ST_RMD_RUN = 3'd3,
      ST_OUT     = 3'd4
   } state_t;

   localparam int BLOCK_BYTES = 64;
   localparam int BLOCK_W     = BLOCK_BYTES * 8;
   localparam int SHA_DIG_W   = 256;
   localparam int RMD_DIG_W   = 160;

   // Tail of the RIPEMD-160 block: 0x80 marker, zero fill, then the 64-bit
   // message length (256 bits) little-endian in bytes 56..63.
   localparam logic [BLOCK_W-SHA_DIG_W-1:0] RMD_PAD = {8'h80, 184'h0, 8'h00, 8'h01, 48'h0};

   // The 32-byte SHA digest is the whole RIPEMD message, so the block is
   // always the digest followed by the fixed pad.
   function automatic logic [BLOCK_W-1:0] build_rmd_block(input logic [SHA_DIG_W-1:0] digest);
      return {digest, RMD_PAD};
   endfunction

endpackage

// File: rtl/hash160_out_ser.sv
// rtl/hash160_out_ser.sv - Loads the 160-bit result and shifts it out MSB word first
module hash160_out_ser
   import hash160_pkg::*;
#(
   parameter int OUT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [RMD_DIG_W-1:0] data,
   output logic [OUT_W-1:0]     tdata,
   output logic                 tvalid,
   output logic                 tlast
);

   localparam int NUM_WORDS = RMD_DIG_W / OUT_W;
   localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

   logic [RMD_DIG_W-1:0] shreg;
   logic [CNT_W-1:0]     word_cnt;

   // Shift register and word counter; the register is cleared after the last
   // word so tdata reads 0 whenever nothing is being presented.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg    <= '0;
         word_cnt <= '0;
         tvalid   <= 1'b0;
      end else if (load) begin
         shreg    <= data;
         word_cnt <= '0;
         tvalid   <= 1'b1;
      end else if (tvalid) begin
         if (word_cnt == LAST_IDX) begin
            shreg    <= '0;
            word_cnt <= '0;
            tvalid   <= 1'b0;
         end else begin
            shreg    <= shreg << OUT_W;
            word_cnt <= word_cnt + 1'b1;
         end
      end
   end

   assign tdata = shreg[RMD_DIG_W-1 -: OUT_W];
   assign tlast = tvalid && (word_cnt == LAST_IDX);

endmodule

// File: rtl/hash160_seq_ctrl.sv
// rtl/hash160_seq_ctrl.sv - Hash160 sequencer: byte packer, SHA-256 then RIPEMD-160 launch, result streaming; watchdog under HASH160_TIMEOUT_EN
module hash160_seq_ctrl
   import hash160_pkg::*;
#(
   parameter int OUT_W          = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   input  logic [7:0]           i_text,
   output logic                 o_busy,
   output logic [OUT_W-1:0]     o_answer,
   output logic                 o_valid,
   output logic                 o_err,
   output logic                 sha_start,
   output logic [BLOCK_W-1:0]   sha_block,
   input  logic                 sha_done,
   input  logic [SHA_DIG_W-1:0] sha_digest,
   output logic                 rmd_start,
   output logic [BLOCK_W-1:0]   rmd_block,
   input  logic                 rmd_done,
   input  logic [RMD_DIG_W-1:0] rmd_digest
);

   if ((RMD_DIG_W % OUT_W) != 0) begin : g_bad_out_w
      $error("OUT_W must divide the 160-bit result");
   end
   if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must fit the 16-bit watchdog");
   end

   state_t     state;
   state_t     next_state;
   logic [5:0] byte_cnt;
   logic [5:0] load_slot;
   logic       accept;
   logic       run_first;
   logic       run_entry;
   logic       in_run;
   logic       sha_take;
   logic       rmd_take;
   logic       wd_expire;
   logic       ser_last;

   // Done pulses count only in their own RUN state and never in the launch
   // cycle, so a stale pulse overlapping the start is not mistaken for completion.
   assign in_run    = (state == ST_SHA_RUN) || (state == ST_RMD_RUN);
   assign sha_take  = (state == ST_SHA_RUN) && !run_first && sha_done;
   assign rmd_take  = (state == ST_RMD_RUN) && !run_first && rmd_done;
   assign accept    = ((state == ST_IDLE) || (state == ST_LOAD)) && i_valid;
   assign load_slot = (state == ST_IDLE) ? 6'd0 : byte_cnt;
   assign run_entry = (next_state != state) &&
                      ((next_state == ST_SHA_RUN) || (next_state == ST_RMD_RUN));

`ifdef HASH160_TIMEOUT_EN
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wd_cnt;

   // A done arriving in the expiry cycle takes priority over the timeout.
   assign wd_expire = in_run && (wd_cnt == WD_LAST) && !sha_take && !rmd_take;

   // Watchdog: zero in each launch cycle, counts every cycle of a RUN state.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (run_entry) begin
         wd_cnt <= '0;
      end else if (in_run) begin
         wd_cnt <= wd_cnt + 16'd1;
      end
   end

   // Abort pulse lands in the first IDLE cycle after the expiry.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_err <= 1'b0;
      end else begin
         o_err <= wd_expire;
      end
   end
`else
   assign wd_expire = 1'b0;
   assign o_err     = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (i_valid) next_state = ST_LOAD;
         end
         ST_LOAD: begin
            if (i_valid && (byte_cnt == 6'(BLOCK_BYTES - 1))) next_state = ST_SHA_RUN;
         end
         ST_SHA_RUN: begin
            if (sha_take)       next_state = ST_RMD_RUN;
            else if (wd_expire) next_state = ST_IDLE;
         end
         ST_RMD_RUN: begin
            if (rmd_take)       next_state = ST_OUT;
            else if (wd_expire) next_state = ST_IDLE;
         end
         ST_OUT: begin
            if (ser_last) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Outputs decoded from state; start pulses are the first cycle of each RUN.
   always_comb begin
      o_busy    = 1'b1;
      sha_start = 1'b0;
      rmd_start = 1'b0;
      case (state)
         ST_IDLE, ST_LOAD: o_busy    = 1'b0;
         ST_SHA_RUN:       sha_start = run_first;
         ST_RMD_RUN:       rmd_start = run_first;
         default:          o_busy    = 1'b1;
      endcase
   end

   // Block registers and byte counter. The counter wraps to 0 on byte 63, so
   // every return to IDLE sees it at 0; blocks hold from launch to done
   // because bytes are only accepted in IDLE/LOAD.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt  <= '0;
         run_first <= 1'b0;
         sha_block <= '0;
         rmd_block <= '0;
      end else begin
         run_first <= run_entry;
         if (accept) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
               if (load_slot == 6'(i)) sha_block[BLOCK_W-1-8*i -: 8] <= i_text;
            end
            byte_cnt <= load_slot + 6'd1;
         end
         if (sha_take) begin
            rmd_block <= build_rmd_block(sha_digest);
         end
      end
   end

   hash160_out_ser #(
      .OUT_W (OUT_W)
   ) u_out_ser (
      .clk    (clk),
      .rst    (rst),
      .load   (rmd_take),
      .data   (rmd_digest),
      .tdata  (o_answer),
      .tvalid (o_valid),
      .tlast  (ser_last)
   );

endmodule
